// File: rtl/conv_stream_pkg.sv
// Shared types, FSM encoding, FP16 ReLU helper and LeNet conv-output dimensions
// for the conv-layer output streamer.
package conv_stream_pkg;

  typedef logic [15:0] fp16_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam int FP16_W = 16;

  // LeNet-5 C1 output: 6 maps of 28x28
  localparam int C1_CHANNELS = 6;
  localparam int C1_H_OUT    = 28;
  localparam int C1_W_OUT    = 28;

  // LeNet-5 C3 output: 16 maps of 10x10
  localparam int C3_CHANNELS = 16;
  localparam int C3_H_OUT    = 10;
  localparam int C3_W_OUT    = 10;

  // Any word with the sign bit set (negatives, -0, negative NaN) clamps to +0
  function automatic fp16_t relu_fp16(input fp16_t w);
    return w[FP16_W-1] ? fp16_t'(16'h0000) : w;
  endfunction

endpackage

// File: rtl/conv_stream_addr_gen.sv
// Frame address generator: word index, pixel/channel counters and last flag.
// Advances on fire_i, clears on clear_i (accepted start), wraps after the last word.
module conv_stream_addr_gen
  import conv_stream_pkg::*;
#(
  parameter int H_OUT    = C3_H_OUT,
  parameter int W_OUT    = C3_W_OUT,
  parameter int CHANNELS = C3_CHANNELS,
  parameter int IDX_W    = $clog2(CHANNELS * H_OUT * W_OUT),
  parameter int CH_W     = $clog2(CHANNELS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             fire_i,
  output logic [IDX_W-1:0] idx_o,
  output logic [CH_W-1:0]  channel_o,
  output logic             last_o
);

  localparam int PIX       = H_OUT * W_OUT;
  localparam int NUM_WORDS = CHANNELS * PIX;
  localparam int PIX_W     = (PIX > 1) ? $clog2(PIX) : 1;

  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_WORDS - 1);
  localparam logic [PIX_W-1:0] PIX_MAX = PIX_W'(PIX - 1);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [PIX_W-1:0] pix_q, pix_d;
  logic [CH_W-1:0]  ch_q,  ch_d;
  logic             at_last;

  assign at_last = (idx_q == IDX_MAX);

  // Channel index comes from a pixel counter rolling into a channel counter,
  // so no divider is needed on the idx path.
  always_comb begin
    idx_d = idx_q;
    pix_d = pix_q;
    ch_d  = ch_q;
    if (clear_i) begin
      idx_d = '0;
      pix_d = '0;
      ch_d  = '0;
    end else if (fire_i) begin
      if (at_last) begin
        idx_d = '0;
        pix_d = '0;
        ch_d  = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
        if (pix_q == PIX_MAX) begin
          pix_d = '0;
          ch_d  = ch_q + CH_W'(1);
        end else begin
          pix_d = pix_q + PIX_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      idx_q <= '0;
      pix_q <= '0;
      ch_q  <= '0;
    end else begin
      idx_q <= idx_d;
      pix_q <= pix_d;
      ch_q  <= ch_d;
    end
  end

  assign idx_o     = idx_q;
  assign channel_o = ch_q;
  assign last_o    = at_last;

endmodule

// File: rtl/conv_output_streamer.sv
// Snapshots the packed conv-layer output bus and streams it one word per cycle
// over valid/ready. Optional ReLU on the read path: define CONV_STREAM_RELU_EN.
module conv_output_streamer
  import conv_stream_pkg::*;
#(
  parameter int DATA_WIDTH = FP16_W,
  parameter int H_OUT      = C3_H_OUT,
  parameter int W_OUT      = C3_W_OUT,
  parameter int CHANNELS   = C3_CHANNELS
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         start,
  input  logic [CHANNELS*H_OUT*W_OUT*DATA_WIDTH-1:0]   data_in,
  output logic [DATA_WIDTH-1:0]                        out_data,
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic                                         out_last,
  output logic [$clog2(CHANNELS)-1:0]                  out_channel,
  output logic                                         busy,
  output logic                                         done
);

  localparam int NUM_WORDS = CHANNELS * H_OUT * W_OUT;
  localparam int IDX_W     = $clog2(NUM_WORDS);
  localparam int CH_W      = $clog2(CHANNELS);

  state_e state_q;
  logic   valid_q;
  logic   busy_q;
  logic   done_q;

  logic [DATA_WIDTH-1:0] snap_q [NUM_WORDS];

  logic             accept;
  logic             fire;
  logic             last;
  logic [IDX_W-1:0] idx;
  logic [CH_W-1:0]  channel;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] out_word;

  assign accept = (state_q == IDLE) && start;
  assign fire   = valid_q && out_ready;

  // Snapshot is data only: it is loaded solely on an accepted start, so a
  // start seen while streaming never disturbs the frame in flight.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        snap_q[i] <= data_in[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= STREAM;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        STREAM: begin
          if (fire && last) begin
            state_q <= DONE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  conv_stream_addr_gen #(
    .H_OUT    (H_OUT),
    .W_OUT    (W_OUT),
    .CHANNELS (CHANNELS),
    .IDX_W    (IDX_W),
    .CH_W     (CH_W)
  ) u_addr_gen (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (accept),
    .fire_i    (fire),
    .idx_o     (idx),
    .channel_o (channel),
    .last_o    (last)
  );

  assign rd_word = snap_q[idx];

`ifdef CONV_STREAM_RELU_EN
  assign out_word = relu_fp16(rd_word);
`else
  assign out_word = rd_word;
`endif

  // Data is forced to zero outside a valid beat so idle/reset outputs are clean.
  assign out_data    = valid_q ? out_word : '0;
  assign out_valid   = valid_q;
  assign out_last    = valid_q && last;
  assign out_channel = channel;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_conv_output_streamer.sv
// Self-checking bench for conv_output_streamer: per-cycle vector table plus
// frame scoreboard built from a word-list model of the snapshot.
module tb_conv_output_streamer;

  localparam int DW = 16;
  localparam int H  = 10;
  localparam int W  = 10;
  localparam int C  = 16;
  localparam int N  = C * H * W;

  logic              clk;
  logic              reset;
  logic              start;
  logic [N*DW-1:0]   data_in;
  logic [DW-1:0]     out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic [3:0]        out_channel;
  logic              busy;
  logic              done;

  conv_output_streamer #(
    .DATA_WIDTH (DW),
    .H_OUT      (H),
    .W_OUT      (W),
    .CHANNELS   (C)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .data_in     (data_in),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .out_channel (out_channel),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc_cnt = 0;

  always @(posedge clk) cyc_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [15:0] data;
    int          ch;
    bit          last;
  } exp_t;

  logic [15:0] img [N];
  exp_t        exp_q [$];

  function automatic logic [15:0] model_word(input logic [15:0] w);
`ifdef CONV_STREAM_RELU_EN
    if (w[15]) return 16'h0000;
`endif
    return w;
  endfunction

  task automatic load_ramp();
    for (int i = 0; i < N; i++) img[i] = 16'(i);
  endtask

  task automatic load_random();
    for (int i = 0; i < N; i++) img[i] = 16'($urandom);
  endtask

  task automatic drive_img();
    for (int i = 0; i < N; i++) data_in[i*DW +: DW] = img[i];
  endtask

  // ---------------- monitor / scoreboard ----------------
  bit          mon_en = 0;
  int          hs_cnt = 0;
  int          done_cnt = 0;
  int          last_hs_cyc = 0;
  int          done_cyc = 0;
  bit          stall_prev = 0;
  logic [15:0] stall_data = '0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (stall_prev) begin
        chk($sformatf("hold_valid@%0d", hs_cnt), 32'(out_valid), 32'd1);
        chk($sformatf("hold_data@%0d", hs_cnt), 32'(out_data), 32'(stall_data));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_word", 32'(hs_cnt), 32'(N));
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk($sformatf("word%0d{data,ch,last}", hs_cnt),
              32'({out_data, out_channel, out_last}),
              32'({e.data, 4'(e.ch), e.last}));
        end
        hs_cnt++;
        last_hs_cyc = cyc_cnt;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc_cnt;
      end
      stall_prev = out_valid && !out_ready && reset;
      stall_data = out_data;
    end
  end

  task automatic start_frame();
    drive_img();
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      exp_t e;
      e.data = model_word(img[i]);
      e.ch   = i / (H * W);
      e.last = (i == N - 1);
      exp_q.push_back(e);
    end
    hs_cnt   = 0;
    done_cnt = 0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("first_valid", 32'({out_valid, busy, done}), 32'b110);
    chk("first_word", 32'(out_data), 32'(model_word(img[0])));
  endtask

  task automatic wait_done(input bit rnd_ready);
    for (int k = 0; k < 8 * N && done_cnt == 0; k++) begin
      if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    chk("done_seen", 32'(done_cnt > 0), 32'd1);
    out_ready = 1'b1;
    repeat (3) cyc();
    chk("done_once", 32'(done_cnt), 32'd1);
    chk("handshakes", 32'(hs_cnt), 32'(N));
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("done_latency", 32'(done_cyc - last_hs_cyc), 32'd1);
    chk("idle_after", 32'({out_valid, busy, done, out_last}), 32'd0);
  endtask

  task automatic wait_word(input logic [15:0] w, input string name);
    int k;
    k = 0;
    while (!(out_valid && out_data == w) && k < 4 * N) begin
      cyc();
      k++;
    end
    chk(name, 32'(out_valid && out_data == w), 32'd1);
  endtask

  // ---------------- per-cycle vector table ----------------
  typedef struct {
    bit          rst_n, st, rdy;
    bit          v, b, d, l;
    logic [15:0] data;
    logic [3:0]  ch;
  } vec_t;

  vec_t vecs [10];

  initial begin
    reset     = 1'b0;
    start     = 1'b0;
    out_ready = 1'b0;
    data_in   = '0;
    load_ramp();
    drive_img();

    //             rst st rdy  v  b  d  l  data      ch
    vecs[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'd0};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'd0};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 4'd0};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 4'd0};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0001, 4'd0};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0002, 4'd0};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0002, 4'd0};
    vecs[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0003, 4'd0};
    vecs[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'd0};
    vecs[9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'd0};

    repeat (2) cyc();
    chk("reset_state", 32'({out_valid, busy, done, out_last, out_channel, out_data}), 32'd0);

    for (int i = 0; i < 10; i++) begin
      reset     = vecs[i].rst_n;
      start     = vecs[i].st;
      out_ready = vecs[i].rdy;
      cyc();
      chk($sformatf("vec%0d", i),
          32'({out_valid, busy, done, out_last, out_channel, out_data}),
          32'({vecs[i].v, vecs[i].b, vecs[i].d, vecs[i].l, vecs[i].ch, vecs[i].data}));
    end
    reset = 1'b1;
    start = 1'b0;
    cyc();
    mon_en = 1;

    // Ramp frame at full throughput
    load_ramp();
    out_ready = 1'b1;
    start_frame();
    wait_done(1'b0);

    // Backpressure on word 5
    start_frame();
    wait_word(16'h0005, "reach_word5");
    out_ready = 1'b0;
    chk("bp_c1", 32'({out_valid, out_data}), 32'h10005);
    cyc();
    chk("bp_c2", 32'({out_valid, out_data}), 32'h10005);
    cyc();
    chk("bp_c3", 32'({out_valid, out_data}), 32'h10005);
    cyc();
    out_ready = 1'b1;
    chk("bp_c4", 32'({out_valid, out_data}), 32'h10005);
    cyc();
    chk("bp_next", 32'({out_valid, out_data}), 32'h10006);
    wait_done(1'b0);

    // Start while busy with a changed bus must not disturb the frame
    start_frame();
    wait_word(16'd200, "reach_word200");
    data_in = '1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("busy_on_restart", 32'({busy, out_valid}), 32'b11);
    wait_done(1'b0);
    repeat (3) cyc();
    chk("no_queued_start", 32'({out_valid, busy}), 32'd0);
    drive_img();

    // Reset mid-frame at word 100
    start_frame();
    wait_word(16'd100, "reach_word100");
    reset = 1'b0;
    out_ready = 1'b0;
    cyc();
    reset = 1'b1;
    chk("rst_mid_outputs", 32'({out_valid, busy, done, out_last, out_data}), 32'd0);
    repeat (5) cyc();
    chk("rst_mid_no_done", 32'(done_cnt), 32'd0);
    out_ready = 1'b1;
    start_frame();
    wait_done(1'b0);

    // ReLU corner words
    load_random();
    img[0] = 16'hC000;
    img[1] = 16'h8000;
    img[2] = 16'h3C00;
    out_ready = 1'b1;
    start_frame();
`ifdef CONV_STREAM_RELU_EN
    chk("relu_w0", 32'(out_data), 32'h0000);
    cyc();
    chk("relu_w1", 32'(out_data), 32'h0000);
`else
    chk("relu_w0", 32'(out_data), 32'hC000);
    cyc();
    chk("relu_w1", 32'(out_data), 32'h8000);
`endif
    cyc();
    chk("relu_w2", 32'(out_data), 32'h3C00);
    wait_done(1'b0);

    // Random data with random backpressure
    for (int f = 0; f < 2; f++) begin
      load_random();
      out_ready = 1'b1;
      start_frame();
      wait_done(1'b1);
    end

    mon_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
